text_row_reader: RTL and testbench
==================================

Name: text_row_reader

Overview:
- Read-side counterpart of the terminal stream writer.
- Fetches one text row of 32-bit character cells from SDRAM, using the same {row, column, 2'b00} address layout and the same first_row scroll offset that the writer publishes over the video register bus.
- Stores each row in a ping-pong line buffer so the video pipeline can read cells randomly while the next row is prefetched.

Parameters:
- COLUMNS, 80, visible cells per row (≤ 128).
- ROWS, 51, text rows per page. The physical row wraps at this value.
- BURST, 16, cells per SDRAM read burst (1..COLUMNS).
- SET_FIRST_ROW_INDEX, 4'd1, register_index code that carries the first-row update.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- register_index  in  4  video register select, from the terminal stream.
- register_value  in  23  video register value. Bits [14:9] hold first_row.
- row_fetch  in  1  one-cycle pulse: swap banks and start prefetching row_number.
- row_number  in  6  logical (on-screen) row to prefetch. Sampled with row_fetch.
- busy  out  1  a fetch is in progress.
- rd_address  out  23  SDRAM byte address of the burst start.
- rd_request  out  1  one-cycle burst request pulse.
- rd_burst_length  out  9  cells in the current burst.
- rd_data  in  32  SDRAM read word.
- rd_data_valid  in  1  rd_data holds the next word of the burst.
- rd_done  in  1  one-cycle pulse: burst complete.
- cell_index  in  7  front-bank read index, from the video pipeline.
- cell_data  out  32  front-bank cell, registered, 1-cycle latency.
- overrun  out  1  sticky error flag (see Optional Feature).

Behaviour:
- Reset values:
  - busy=0, rd_request=0, rd_address=0, rd_burst_length=1, cell_data=0, overrun=0.
  - first_row=0, front bank=0, state IDLE.
  - Buffer contents are undefined after reset.
- first_row register:
  - When register_index==SET_FIRST_ROW_INDEX, first_row_pending <= register_value[14:9]. This is checked every cycle, in any state.
  - first_row_pending is copied into the active first_row only when a fetch starts, so a fetch in progress never mixes offsets.
- Physical row:
  - phys = row_number + first_row.
  - If phys ≥ ROWS, subtract ROWS. Use 7-bit intermediate arithmetic so the sum cannot overflow.
- Row base address: {8'b0, phys[5:0], 7'b0, 2'b00}. Cell k is at base + 4k.
- State machine states: IDLE, REQUEST, RECEIVE, NEXT.
- IDLE:
  - On row_fetch: toggle the front bank, latch phys, set cell counter=0 and fill index=0, set busy=1, go to REQUEST.
- REQUEST:
  - rd_address = base + 4·cell counter.
  - rd_burst_length = min(BURST, COLUMNS − cell counter).
  - rd_request=1 for exactly one cycle, then go to RECEIVE.
- RECEIVE:
  - Each rd_data_valid writes rd_data into the back bank at the fill index, then increments the fill index.
  - On rd_done, go to NEXT. rd_data_valid and rd_done may coincide; the word is still written.
- NEXT:
  - Add the burst length to the cell counter.
  - If cell counter == COLUMNS: busy=0, go to IDLE.
  - Otherwise go to REQUEST.
  - Total fetch for 80/16 is 5 bursts: lengths 16,16,16,16,16.
- Extra words: rd_data_valid beyond COLUMNS words is discarded. The fill index saturates and never wraps into cell 0.
- Front-bank reads:
  - Reads never touch the back bank.
  - cell_index ≥ COLUMNS returns 32'h0.
- row_fetch while busy:
  - The pulse is ignored: no bank swap and no restart.
  - The current fetch completes normally.
  - The overrun flag is handled per the Optional Feature.
- Reset mid-fetch: abort immediately. rd_request=0. Any rd_data_valid or rd_done that arrives afterwards is ignored in IDLE.

Optional Feature:
- TEXT_ROW_READER_OVERRUN_EN:
  - Defined: overrun sets to 1 on any row_fetch that arrives while busy=1. It stays set until reset.
  - Undefined: overrun is tied to 0 and the detection logic is not built. The ignore-while-busy behaviour is unchanged.

Test Plan:
- reset, first_row=0, row_fetch row_number=3 → 5 requests at addresses 0x600, 0x640, 0x680, 0x6C0, 0x700, each with length 16. busy falls after the 5th rd_done. After the next row_fetch, cell_index 0..79 return the written pattern.
- register_index=SET_FIRST_ROW_INDEX with value {6'd50, 9'b0} (ROWS=51), then row_fetch row 2 → phys=1, first address 0x200.
- COLUMNS=80, BURST=32 → burst lengths 32, 32, 16. Exactly 80 words are stored. A 33rd rd_data_valid in the last burst is dropped.
- row_fetch pulsed during the 2nd burst → no bank swap, fetch finishes. overrun=1 with the macro defined, 0 without.
- first_row update written mid-fetch → all bursts of that fetch use the old offset. The next fetch uses the new offset.
- reset asserted in RECEIVE, then stray rd_done → state IDLE, busy=0, no rd_request, overrun=0.

Source files
------------

// File: rtl/text_row_reader.sv
// Fetches one text row of character cells from SDRAM into a ping-pong line buffer.
// Optional sticky overrun flag is built when TEXT_ROW_READER_OVERRUN_EN is defined.
module text_row_reader #(
    parameter int         COLUMNS             = 80,
    parameter int         ROWS                = 51,
    parameter int         BURST               = 16,
    parameter logic [3:0] SET_FIRST_ROW_INDEX = 4'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  register_index,
    input  logic [22:0] register_value,
    input  logic        row_fetch,
    input  logic [5:0]  row_number,
    output logic        busy,
    output logic [22:0] rd_address,
    output logic        rd_request,
    output logic [8:0]  rd_burst_length,
    input  logic [31:0] rd_data,
    input  logic        rd_data_valid,
    input  logic        rd_done,
    input  logic [6:0]  cell_index,
    output logic [31:0] cell_data,
    output logic        overrun
);

    // state   | meaning
    // IDLE    | waiting for row_fetch
    // REQUEST | rd_request pulse with address and length of the next burst
    // RECEIVE | storing burst words into the back bank until rd_done
    // NEXT    | advance cell counter, finish or request another burst
    typedef enum logic [1:0] {IDLE, REQUEST, RECEIVE, NEXT} state_t;

    localparam logic [7:0] COLS8  = 8'(COLUMNS);
    localparam logic [7:0] BURST8 = 8'(BURST);

    state_t      state, state_next;
    logic        start;
    logic [5:0]  first_row_pending, first_row, row_latched;
    logic [6:0]  phys_sum, phys_full;
    logic [7:0]  cell_count, count_next, remaining, len_next;
    logic [7:0]  fill_index;
    logic        front;
    logic        fill_write;
    logic [31:0] bank [2][COLUMNS];
    logic        unused_bits;

    assign unused_bits = ^{register_value[22:15], register_value[8:0], phys_full[6]};

    // 7-bit sum so row_number + first_row cannot overflow before the wrap
    assign phys_sum   = {1'b0, row_latched} + {1'b0, first_row};
    assign phys_full  = (phys_sum >= 7'(ROWS)) ? phys_sum - 7'(ROWS) : phys_sum;
    assign rd_address = {8'b0, phys_full[5:0], cell_count[6:0], 2'b00};
    assign busy       = (state != IDLE);
    assign fill_write = (state == RECEIVE) && rd_data_valid && (fill_index < COLS8);

    always_comb begin
        state_next = state;
        start      = 1'b0;
        count_next = cell_count;
        rd_request = 1'b0;
        case (state)
            IDLE: begin
                if (row_fetch) begin
                    start      = 1'b1;
                    count_next = '0;
                    state_next = REQUEST;
                end
            end
            REQUEST: begin
                rd_request = 1'b1;
                state_next = RECEIVE;
            end
            RECEIVE: begin
                if (rd_done) state_next = NEXT;
            end
            NEXT: begin
                count_next = cell_count + rd_burst_length[7:0];
                state_next = (count_next == COLS8) ? IDLE : REQUEST;
            end
            default: state_next = IDLE;
        endcase
        remaining = COLS8 - count_next;
        len_next  = (remaining > BURST8) ? BURST8 : remaining;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            first_row_pending <= '0;
            first_row         <= '0;
            row_latched       <= '0;
            front             <= 1'b0;
            cell_count        <= '0;
            fill_index        <= '0;
            rd_burst_length   <= 9'd1;
            cell_data         <= '0;
        end else begin
            state      <= state_next;
            cell_count <= count_next;
            if (register_index == SET_FIRST_ROW_INDEX)
                first_row_pending <= register_value[14:9];
            // offset is frozen per fetch so all bursts of one row agree
            if (start) begin
                first_row   <= first_row_pending;
                row_latched <= row_number;
                front       <= ~front;
                fill_index  <= '0;
            end else if (fill_write) begin
                fill_index <= fill_index + 8'd1;
            end
            if (state_next == REQUEST)
                rd_burst_length <= {1'b0, len_next};
            if ({1'b0, cell_index} < COLS8)
                cell_data <= bank[front][cell_index];
            else
                cell_data <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && fill_write)
            bank[~front][fill_index[6:0]] <= rd_data;
    end

`ifdef TEXT_ROW_READER_OVERRUN_EN
    always_ff @(posedge clk) begin
        if (reset)
            overrun <= 1'b0;
        else if (row_fetch && busy)
            overrun <= 1'b1;
    end
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_text_row_reader.sv
// Directed bench for text_row_reader: address/offset table, burst split, buffer swap, overrun, reset abort.
module tb_text_row_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  register_index;
    logic [22:0] register_value;
    logic        row_fetch [2];
    logic [5:0]  row_number;
    logic        busy [2];
    logic [22:0] rd_address [2];
    logic        rd_request [2];
    logic [8:0]  rd_burst_length [2];
    logic [31:0] rd_data [2];
    logic        rd_data_valid [2];
    logic        rd_done [2];
    logic [6:0]  cell_index;
    logic [31:0] cell_data [2];
    logic        overrun [2];

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    text_row_reader #(.BURST(16)) dut0 (
        .clk(clk), .reset(reset), .register_index(register_index), .register_value(register_value),
        .row_fetch(row_fetch[0]), .row_number(row_number), .busy(busy[0]), .rd_address(rd_address[0]),
        .rd_request(rd_request[0]), .rd_burst_length(rd_burst_length[0]), .rd_data(rd_data[0]),
        .rd_data_valid(rd_data_valid[0]), .rd_done(rd_done[0]), .cell_index(cell_index),
        .cell_data(cell_data[0]), .overrun(overrun[0])
    );

    text_row_reader #(.BURST(32)) dut1 (
        .clk(clk), .reset(reset), .register_index(register_index), .register_value(register_value),
        .row_fetch(row_fetch[1]), .row_number(row_number), .busy(busy[1]), .rd_address(rd_address[1]),
        .rd_request(rd_request[1]), .rd_burst_length(rd_burst_length[1]), .rd_data(rd_data[1]),
        .rd_data_valid(rd_data_valid[1]), .rd_done(rd_done[1]), .cell_index(cell_index),
        .cell_data(cell_data[1]), .overrun(overrun[1])
    );

    typedef struct {
        logic [5:0]  fr;
        logic [5:0]  row;
        logic [22:0] base;
    } vec_t;

    vec_t vecs [5];
    logic exp_overrun;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] seed(input int v);
        return 32'h5A00_0000 | (32'(v) << 16);
    endfunction

    task automatic set_first_row(input logic [5:0] fr);
        register_index = 4'd1;
        register_value = {8'b0, fr, 9'b0};
        tick();
        register_index = 4'd0;
        register_value = '0;
    endtask

    task automatic start_fetch(input int d, input logic [5:0] row);
        row_number   = row;
        row_fetch[d] = 1'b1;
        tick();
        row_fetch[d] = 1'b0;
    endtask

    task automatic wait_request(input int d);
        int n = 0;
        while (!rd_request[d] && n < 50) begin
            tick();
            n++;
        end
        check("request_seen", {31'b0, rd_request[d]}, 32'd1);
    endtask

    task automatic read_cell(input int d, input int idx, input logic [31:0] exp, input string name);
        cell_index = 7'(idx);
        tick();
        check(name, cell_data[d], exp);
    endtask

    // hook 1: row_fetch pulse during burst 2; hook 2: first_row write during burst 2
    task automatic serve(input int d, input logic [22:0] base, input int burst, input int extra,
                         input logic [31:0] sd, input int hook, input logic [5:0] hook_val);
        int cnt = 0;
        int b = 0;
        int len, n;
        while (cnt < 80) begin
            len = (80 - cnt < burst) ? 80 - cnt : burst;
            wait_request(d);
            check("rd_address", {9'b0, rd_address[d]}, 32'(base) + 32'(4 * cnt));
            check("rd_burst_length", {23'b0, rd_burst_length[d]}, 32'(len));
            check("busy_during", {31'b0, busy[d]}, 32'd1);
            tick();
            check("request_pulse", {31'b0, rd_request[d]}, 32'd0);
            n = len + ((cnt + len == 80) ? extra : 0);
            for (int k = 0; k < n; k++) begin
                rd_data_valid[d] = 1'b1;
                rd_data[d]       = (k < len) ? sd + 32'(cnt + k) : 32'hDEAD_BEEF;
                rd_done[d]       = (k == n - 1);
                if (b == 1 && k == 0 && hook == 1) begin
                    row_number   = hook_val;
                    row_fetch[d] = 1'b1;
                end
                if (b == 1 && k == 0 && hook == 2) begin
                    register_index = 4'd1;
                    register_value = {8'b0, hook_val, 9'b0};
                end
                tick();
                row_fetch[d]     = 1'b0;
                register_index   = 4'd0;
                register_value   = '0;
                rd_data_valid[d] = 1'b0;
                rd_done[d]       = 1'b0;
            end
            cnt += len;
            b++;
        end
        n = 0;
        while (busy[d] && n < 10) begin
            tick();
            n++;
        end
        check("busy_fall", {31'b0, busy[d]}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{fr: 6'd0,  row: 6'd3,  base: 23'h000600};
        vecs[1] = '{fr: 6'd50, row: 6'd2,  base: 23'h000200};
        vecs[2] = '{fr: 6'd10, row: 6'd40, base: 23'h006400};
        vecs[3] = '{fr: 6'd20, row: 6'd31, base: 23'h000000};
        vecs[4] = '{fr: 6'd45, row: 6'd50, base: 23'h005800};
`ifdef TEXT_ROW_READER_OVERRUN_EN
        exp_overrun = 1'b1;
`else
        exp_overrun = 1'b0;
`endif

        reset = 1'b1;
        register_index = '0;
        register_value = '0;
        row_number = '0;
        cell_index = '0;
        for (int d = 0; d < 2; d++) begin
            row_fetch[d] = 1'b0;
            rd_data[d] = '0;
            rd_data_valid[d] = 1'b0;
            rd_done[d] = 1'b0;
        end
        tick(); tick(); tick();
        for (int d = 0; d < 2; d++) begin
            check("reset_busy", {31'b0, busy[d]}, 32'd0);
            check("reset_rd_request", {31'b0, rd_request[d]}, 32'd0);
            check("reset_rd_address", {9'b0, rd_address[d]}, 32'd0);
            check("reset_rd_burst_length", {23'b0, rd_burst_length[d]}, 32'd1);
            check("reset_cell_data", cell_data[d], 32'd0);
            check("reset_overrun", {31'b0, overrun[d]}, 32'd0);
        end
        reset = 1'b0;
        tick();

        for (int v = 0; v < 5; v++) begin
            set_first_row(vecs[v].fr);
            start_fetch(0, vecs[v].row);
            serve(0, vecs[v].base, 16, 0, seed(v), 0, 6'd0);
            if (v == 1) begin
                for (int k = 0; k < 80; k++) read_cell(0, k, seed(0) + 32'(k), "sweep_cell");
            end else if (v > 1) begin
                read_cell(0, 0, seed(v - 1), "front_cell0");
                read_cell(0, 79, seed(v - 1) + 32'd79, "front_cell79");
            end
            read_cell(0, 80, 32'd0, "cell_out_of_range80");
            read_cell(0, 127, 32'd0, "cell_out_of_range127");
        end

        // row_fetch while busy: ignored, no swap
        set_first_row(6'd0);
        start_fetch(0, 6'd5);
        serve(0, 23'h000A00, 16, 0, seed(6), 1, 6'd9);
        check("overrun_flag", {31'b0, overrun[0]}, {31'b0, exp_overrun});
        read_cell(0, 0, seed(4), "no_swap_cell0");
        read_cell(0, 79, seed(4) + 32'd79, "no_swap_cell79");

        // first_row change mid-fetch only affects the following fetch
        set_first_row(6'd7);
        start_fetch(0, 6'd10);
        serve(0, 23'h002200, 16, 0, seed(7), 2, 6'd20);
        read_cell(0, 5, seed(6) + 32'd5, "overrun_fetch_data");
        start_fetch(0, 6'd10);
        serve(0, 23'h003C00, 16, 0, seed(8), 0, 6'd0);
        read_cell(0, 10, seed(7) + 32'd10, "midfetch_data");
        check("overrun_sticky", {31'b0, overrun[0]}, {31'b0, exp_overrun});

        // BURST=32: lengths 32,32,16 and a dropped extra word
        set_first_row(6'd0);
        start_fetch(1, 6'd1);
        serve(1, 23'h000200, 32, 1, seed(9), 0, 6'd0);
        start_fetch(1, 6'd2);
        serve(1, 23'h000400, 32, 0, seed(10), 0, 6'd0);
        read_cell(1, 0, seed(9), "extra_word_cell0");
        read_cell(1, 79, seed(9) + 32'd79, "extra_word_cell79");
        read_cell(1, 80, 32'd0, "extra_word_cell80");
        check("dut1_overrun", {31'b0, overrun[1]}, 32'd0);

        // reset in RECEIVE, then stray completion
        start_fetch(0, 6'd4);
        wait_request(0);
        tick();
        for (int k = 0; k < 3; k++) begin
            rd_data_valid[0] = 1'b1;
            rd_data[0] = 32'h1111_0000 + 32'(k);
            tick();
        end
        rd_data_valid[0] = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", {31'b0, busy[0]}, 32'd0);
        check("abort_rd_request", {31'b0, rd_request[0]}, 32'd0);
        check("abort_overrun", {31'b0, overrun[0]}, 32'd0);
        check("abort_rd_burst_length", {23'b0, rd_burst_length[0]}, 32'd1);
        rd_done[0] = 1'b1;
        rd_data_valid[0] = 1'b1;
        tick();
        rd_done[0] = 1'b0;
        rd_data_valid[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("stray_rd_request", {31'b0, rd_request[0]}, 32'd0);
            check("stray_busy", {31'b0, busy[0]}, 32'd0);
            tick();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
